// File: rtl/comp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comp_pkg                                                        |
// | Brief    : Shared types and helpers for the bit-serial comparator.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int COMP_WIDTH_DEF = 8;

  // Bits needed to hold a counter spanning 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage : comp_pkg
`default_nettype wire

// File: rtl/comp_bit_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comp_bit_cell                                                   |
// | Brief    : Combinational 1-bit magnitude compare cell.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module comp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_gt,
  output logic bit_lt
);

  assign bit_gt = a_bit & ~b_bit;
  assign bit_lt = ~a_bit & b_bit;

endmodule : comp_bit_cell
`default_nettype wire

// File: rtl/comp_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comp_serial_ctrl                                                |
// | Brief    : MSB-first bit-serial unsigned magnitude comparator with         |
// |            start/ready handshake and a one-cycle done pulse.               |
// |            Define COMP_EARLY_EXIT_EN to finish on the first differing bit. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module comp_serial_ctrl
  import comp_pkg::*;
#(
  parameter int WIDTH = COMP_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int CNT_W = clog2(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               decided_q, decided_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               a_gt_b_q, a_gt_b_d;
  logic               a_eq_b_q, a_eq_b_d;
  logic               a_lt_b_q, a_lt_b_d;

  logic               bit_gt;
  logic               bit_lt;
  logic               diff_now;
  logic               last_bit;
  logic               finish;

  comp_bit_cell u_cell (
    .a_bit  (sa_q[WIDTH-1]),
    .b_bit  (sb_q[WIDTH-1]),
    .bit_gt (bit_gt),
    .bit_lt (bit_lt)
  );

  assign diff_now = ~decided_q & (bit_gt | bit_lt);
  assign last_bit = (cnt_q == '0);

`ifdef COMP_EARLY_EXIT_EN
  assign finish = last_bit | diff_now;
`else
  assign finish = last_bit;
`endif

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    a_gt_b_d  = a_gt_b_q;
    a_eq_b_d  = a_eq_b_q;
    a_lt_b_d  = a_lt_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d      = a;
          sb_d      = b;
          cnt_d     = CNT_W'(WIDTH - 1);
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (diff_now) begin
          gt_d      = bit_gt;
          lt_d      = bit_lt;
          decided_d = 1'b1;
        end
        sa_d  = {sa_q[WIDTH-2:0], 1'b0};
        sb_d  = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        // Flags take the post-update verdict so the deciding bit itself counts.
        if (finish) begin
          a_gt_b_d = gt_d;
          a_lt_b_d = lt_d;
          a_eq_b_d = ~decided_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      a_gt_b_q  <= 1'b0;
      a_eq_b_q  <= 1'b0;
      a_lt_b_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      a_gt_b_q  <= a_gt_b_d;
      a_eq_b_q  <= a_eq_b_d;
      a_lt_b_q  <= a_lt_b_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign a_gt_b = a_gt_b_q;
  assign a_eq_b = a_eq_b_q;
  assign a_lt_b = a_lt_b_q;

endmodule : comp_serial_ctrl
`default_nettype wire

// File: tb/tb_comp_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_comp_serial_ctrl                                             |
// | Brief    : Self-checking bench for comp_serial_ctrl (both build options).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_comp_serial_ctrl;

  localparam int WIDTH = 8;
`ifdef COMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;

  int n_checks = 0;
  int n_pass   = 0;

  comp_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  always #5 clk = ~clk;

  // Reference: flags from plain integer comparison.
  function automatic logic [2:0] exp_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {x > y, x == y, x < y};
  endfunction

  // Reference: cycles from accepting edge to done, counted as in the data sheet.
  function automatic int exp_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (!EARLY || x == y) return WIDTH + 1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return (WIDTH - i) + 1;
    end
    return WIDTH + 1;
  endfunction

  // Present operands with start for one accepting edge; returns at the next negedge.
  task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; returns at the negedge where done was seen.
  task automatic wait_done(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 4 * WIDTH && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat = i + 2;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ready, busy, done} !== 3'b100)
      $display("FAIL reset_ctrl: ready/busy/done=%b required 100", {ready, busy, done});
    else n_pass++;
    n_checks++;
    if ({a_gt_b, a_eq_b, a_lt_b} !== 3'b000)
      $display("FAIL reset_flags: gt/eq/lt=%b required 000", {a_gt_b, a_eq_b, a_lt_b});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] xs[4] = '{8'd100, 8'd25, 8'd150, 8'd0};
    logic [WIDTH-1:0] ys[4] = '{8'd50,  8'd75, 8'd150, 8'd0};
    int lat;
    bit seen;
    for (int k = 0; k < 4; k++) begin
      launch(xs[k], ys[k]);
      n_checks++;
      if ({ready, busy} !== 2'b01)
        $display("FAIL dir%0d_busy: ready/busy=%b required 01", k, {ready, busy});
      else n_pass++;
      wait_done(lat, seen);
      n_checks++;
      if (!seen || lat != exp_latency(xs[k], ys[k]))
        $display("FAIL dir%0d_latency: seen=%0d lat=%0d required %0d", k, seen, lat, exp_latency(xs[k], ys[k]));
      else n_pass++;
      n_checks++;
      if ({a_gt_b, a_eq_b, a_lt_b} !== exp_flags(xs[k], ys[k]))
        $display("FAIL dir%0d_flags: gt/eq/lt=%b required %b", k, {a_gt_b, a_eq_b, a_lt_b}, exp_flags(xs[k], ys[k]));
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({done, ready} !== 2'b01)
        $display("FAIL dir%0d_pulse: done/ready=%b required 01", k, {done, ready});
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        n_checks++;
        if ({a_gt_b, a_eq_b, a_lt_b, done} !== {exp_flags(xs[k], ys[k]), 1'b0})
          $display("FAIL dir%0d_hold: gt/eq/lt/done=%b required %b0", k, {a_gt_b, a_eq_b, a_lt_b, done}, exp_flags(xs[k], ys[k]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    int extra;
    launch(8'd255, 8'd0);
    // Request arriving while busy must be dropped.
    a     = 8'd0;
    b     = 8'd255;
    start = 1'b1;
    wait_done(lat, seen);
    start = 1'b0;
    n_checks++;
    if (!seen || {a_gt_b, a_eq_b, a_lt_b} !== 3'b100)
      $display("FAIL b2b_first: seen=%0d gt/eq/lt=%b required 100", seen, {a_gt_b, a_eq_b, a_lt_b});
    else n_pass++;
    extra = 0;
    for (int c = 0; c < WIDTH + 3; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra != 0 || ready !== 1'b1)
      $display("FAIL b2b_no_queue: extra_done=%0d ready=%b required 0 and 1", extra, ready);
    else n_pass++;
    launch(8'd0, 8'd255);
    wait_done(lat, seen);
    n_checks++;
    if (!seen || lat != exp_latency(8'd0, 8'd255) || {a_gt_b, a_eq_b, a_lt_b} !== 3'b001)
      $display("FAIL b2b_second: seen=%0d lat=%0d gt/eq/lt=%b required lat %0d flags 001",
               seen, lat, {a_gt_b, a_eq_b, a_lt_b}, exp_latency(8'd0, 8'd255));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    int extra;
    launch(8'd100, 8'd50);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, busy, done, a_gt_b, a_eq_b, a_lt_b} !== 6'b100000)
      $display("FAIL midrst_clear: ready/busy/done/gt/eq/lt=%b required 100000",
               {ready, busy, done, a_gt_b, a_eq_b, a_lt_b});
    else n_pass++;
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) extra++;
    end
    rst = 1'b0;
    for (int c = 0; c < WIDTH + 3; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra != 0)
      $display("FAIL midrst_no_done: done_pulses=%0d required 0", extra);
    else n_pass++;
    launch(8'd100, 8'd50);
    wait_done(lat, seen);
    n_checks++;
    if (!seen || lat != exp_latency(8'd100, 8'd50) || {a_gt_b, a_eq_b, a_lt_b} !== 3'b100)
      $display("FAIL midrst_recover: seen=%0d lat=%0d gt/eq/lt=%b required lat %0d flags 100",
               seen, lat, {a_gt_b, a_eq_b, a_lt_b}, exp_latency(8'd100, 8'd50));
    else n_pass++;
  endtask

  task automatic test_operand_change();
    int lat;
    bit seen;
    launch(8'd100, 8'd50);
    a = 8'd0;
    b = 8'd255;
    wait_done(lat, seen);
    n_checks++;
    if (!seen || {a_gt_b, a_eq_b, a_lt_b} !== 3'b100)
      $display("FAIL opchg_flags: seen=%0d gt/eq/lt=%b required 100", seen, {a_gt_b, a_eq_b, a_lt_b});
    else n_pass++;
    n_checks++;
    if (a_eq_b !== ~(a_gt_b | a_lt_b))
      $display("FAIL opchg_onehot: eq=%b required %b", a_eq_b, ~(a_gt_b | a_lt_b));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0)
      $display("FAIL opchg_pulse_width: done=%b required 0", done);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    int lat;
    bit seen;
    for (int n = 0; n < 24; n++) begin
      x = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: y = WIDTH'($urandom);
      endcase
      launch(x, y);
      wait_done(lat, seen);
      n_checks++;
      if (!seen || lat != exp_latency(x, y))
        $display("FAIL rnd%0d_latency a=%0d b=%0d: seen=%0d lat=%0d required %0d", n, x, y, seen, lat, exp_latency(x, y));
      else n_pass++;
      n_checks++;
      if ({a_gt_b, a_eq_b, a_lt_b} !== exp_flags(x, y))
        $display("FAIL rnd%0d_flags a=%0d b=%0d: gt/eq/lt=%b required %b", n, x, y, {a_gt_b, a_eq_b, a_lt_b}, exp_flags(x, y));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_operand_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_comp_serial_ctrl
`default_nettype wire
